// File: rtl/left_shift_iter.sv
// -----------------------------------------------------------------------------
// left_shift_iter
//   Iterative 32-bit left shifter. An operand pair (a, b) is accepted in IDLE,
//   then one logarithmic stage (shift by 1, 2, 4, 8, 16) is applied per cycle
//   for exactly five cycles regardless of b. The result is then held on w5
//   with out_valid until the consumer takes it.
//
//   Optional build macro:
//     LSHIFT_ROTATE_EN - when defined, each stage rotates left (bits leaving
//                        bit 31 re-enter at bit 0) instead of zero-filling.
//
// Ports:
//   clk        in   1   clock, all state on rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand pair offered
//   in_ready   out  1   block can accept operands (IDLE only)
//   a          in  32   value to shift
//   b          in   5   shift amount 0..31
//   out_valid  out  1   result held on w5
//   out_ready  in   1   consumer takes result
//   w5         out 32   shifted result (meaningful only while out_valid=1)
//   busy       out  1   high in SHIFT or DONE
// -----------------------------------------------------------------------------
module left_shift_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [4:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] w5,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_amount;
  logic [2:0]  r_stage;
  logic        r_out_valid;
  logic        r_busy;

  logic        w_amt_bit;
  logic [31:0] w_next_acc;

  // Apply log stage k (distance 2^k) unconditionally to the accumulator value.
  function automatic logic [31:0] stage_shift(input logic [31:0] acc, input logic [2:0] k);
    logic [31:0] res;
    case (k)
`ifdef LSHIFT_ROTATE_EN
      3'd0:    res = {acc[30:0], acc[31:31]};
      3'd1:    res = {acc[29:0], acc[31:30]};
      3'd2:    res = {acc[27:0], acc[31:28]};
      3'd3:    res = {acc[23:0], acc[31:24]};
      3'd4:    res = {acc[15:0], acc[31:16]};
`else
      3'd0:    res = {acc[30:0], 1'b0};
      3'd1:    res = {acc[29:0], 2'b00};
      3'd2:    res = {acc[27:0], 4'h0};
      3'd3:    res = {acc[23:0], 8'h00};
      3'd4:    res = {acc[15:0], 16'h0000};
`endif
      default: res = acc;
    endcase
    return res;
  endfunction

  // Select the amount bit that controls the current stage.
  always_comb begin
    w_amt_bit = 1'b0;
    case (r_stage)
      3'd0:    w_amt_bit = r_amount[0];
      3'd1:    w_amt_bit = r_amount[1];
      3'd2:    w_amt_bit = r_amount[2];
      3'd3:    w_amt_bit = r_amount[3];
      3'd4:    w_amt_bit = r_amount[4];
      default: w_amt_bit = 1'b0;
    endcase
  end

  // Next accumulator value for the current stage: shifted if its amount bit is set.
  always_comb begin
    w_next_acc = r_acc;
    if (w_amt_bit) begin
      w_next_acc = stage_shift(r_acc, r_stage);
    end else begin
      w_next_acc = r_acc;
    end
  end

  // Control FSM with datapath registers; all outputs except in_ready are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= 32'h0000_0000;
      r_amount    <= 5'd0;
      r_stage     <= 3'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_acc    <= a;
            r_amount <= b;
            r_stage  <= 3'd0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Always run all five stages so latency does not depend on b.
          r_acc   <= w_next_acc;
          r_stage <= r_stage + 3'd1;
          if (r_stage == 3'd4) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign w5        = r_acc;
  assign busy      = r_busy;

endmodule

// File: tb/tb_left_shift_iter.sv
module tb_left_shift_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] w5;
  logic        busy;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    logic [31:0] exp;
    int          acc_cyc;
  } sb_t;
  sb_t q[$];

  left_shift_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .w5(w5), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic shift / rotate.
  function automatic logic [31:0] model(input logic [31:0] av, input logic [4:0] bv);
    logic [31:0] r;
`ifdef LSHIFT_ROTATE_EN
    if (bv == 5'd0) r = av;
    else r = (av << bv) | (av >> (6'd32 - {1'b0, bv}));
`else
    r = av << bv;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: input side pushes expectations, output side checks.
  logic        prev_ov;
  logic        prev_rdy;
  logic [31:0] held;
  initial begin
    prev_ov  = 1'b0;
    prev_rdy = 1'b0;
    held     = 32'h0;
  end
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (prev_ov && !prev_rdy) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_w5", w5, held);
      end
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
        else chk("latency", cyc, q[0].acc_cyc + 5);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_result", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("result", w5, e.exp);
        end
      end
      if (in_valid && in_ready) begin
        e.exp = model(a, b);
        e.acc_cyc = cyc + 1;
        q.push_back(e);
      end
      prev_ov  = out_valid;
      prev_rdy = out_ready;
      held     = w5;
    end else begin
      q.delete();
      prev_ov  = 1'b0;
      prev_rdy = 1'b0;
    end
  end

  task automatic send(input logic [31:0] av, input logic [4:0] bv);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = av; b = bv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      a = $urandom; b = 5'($urandom);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = 32'h0; b = 5'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_w5", w5, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Directed corner cases, consumer always ready.
    send(32'h0000_0001, 5'd31); wait_idle(1'b0);
    send(32'h8000_0001, 5'd1);  wait_idle(1'b0);
    send(32'hFFFF_FFFF, 5'd4);  wait_idle(1'b0);
    send(32'h1234_5678, 5'd0);  wait_idle(1'b0);

    // Back-pressure in DONE with inputs toggling.
    out_ready = 1'b0;
    send(32'hA5A5_0F0F, 5'd7);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (out_valid) begin seen = 1'b1; break; end
      end
      if (!seen) chk("done_wait_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid; a = $urandom; b = 5'($urandom);
      #1 chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
      chk("busy_in_done", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("retire_valid", {31'd0, out_valid}, 32'd0);
    chk("retire_queue", q.size(), 32'd0);

    // Reset during stage 2.
    send(32'hDEAD_BEEF, 5'd13);
    @(posedge clk); @(posedge clk); #1;
    chk("busy_in_shift", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_w5", w5, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (10) @(negedge clk);

    // Randomized traffic with random back-pressure.
    for (int n = 0; n < 40; n++) begin
      logic [4:0] bb;
      bb = 5'($urandom);
      if (n % 8 == 0) bb = 5'd0;
      if (n % 8 == 1) bb = 5'd31;
      send($urandom, bb);
      wait_idle(1'b1);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
